// File: rtl/decap_packet_pkg.sv
// Shared definitions for the Aurora flit encapsulator/decapsulator pair.
// Holds the DFX word geometry, the 9-bit flit header layout and the
// decapsulator state encoding.
package decap_packet_pkg;

    // DFX word geometry
    localparam int unsigned DATA_DFX_WIDTH = 1034;
    localparam int unsigned HEADER_WIDTH   = 9;
    localparam int unsigned PAYLOAD_WIDTH  = 55;
    localparam int unsigned NUMBER_PACKET  = 19;

    // Flit index counter width (0..NUMBER_PACKET-1)
    localparam int unsigned INDEX_WIDTH    = 5;

    // Header field offsets: {router_id[8:7], flit_cnt[6:2], ttl[1:0]}
    localparam int unsigned HDR_TTL_LSB    = 0;
    localparam int unsigned HDR_TTL_WIDTH  = 2;
    localparam int unsigned HDR_CNT_LSB    = 2;
    localparam int unsigned HDR_CNT_WIDTH  = 5;
    localparam int unsigned HDR_RID_LSB    = 7;
    localparam int unsigned HDR_RID_WIDTH  = 2;

    // Flit header as carried in bits [8:0] of every flit
    typedef struct packed {
        logic [HDR_RID_WIDTH-1:0] router_id;
        logic [HDR_CNT_WIDTH-1:0] flit_cnt;
        logic [HDR_TTL_WIDTH-1:0] ttl;
    } pkt_header_t;

    // Decapsulator state machine
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } decap_state_e;

endpackage

// File: rtl/decap_packet_flit_gap_timer.sv
// flit_gap_timer: counts consecutive idle cycles while a packet is being
// collected and flags the cycle in which the gap reaches TIMEOUT_CYCLES.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - restart the gap count (valid flit seen or not collecting)
//   enable    - this cycle is an idle cycle inside a packet
//   expired   - combinational: this idle cycle is the TIMEOUT_CYCLES-th one
module flit_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Gap count and expiry detect; the count restarts once it has expired
    always_comb begin
        cnt_d   = cnt_q;
        expired = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == CNT_LAST) begin
                expired = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // Gap count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decap_packet.sv
// decap_packet: reassembles a 1034-bit DFX word from 19 Aurora flits.
// Each flit is {payload[54:0], header[8:0]}; flits 0..17 contribute 55
// payload bits each, flit 18 contributes the top 44 bits. The packet header
// is latched from flit 0 and every later flit must carry the same header.
// The completed word is presented on a valid/ready output register.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   data_out_port_0   - received flit
//   data_decap_valid  - flit qualifier (no backpressure upstream)
//   data_dfx_recv     - reassembled DFX word
//   header_pkt_recv   - header of the reassembled packet
//   dfx_recv_valid    - output word valid
//   dfx_recv_ready    - consumer accepts the output word
//   hdr_err           - pulse: header changed mid-packet, packet dropped
//   timeout_err       - pulse: idle gap too long mid-packet, packet dropped
//   overflow_err      - pulse: completed packet dropped, output still held
module decap_packet
    import decap_packet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = 1024,
    parameter int unsigned ADDR_WIDTH        = 10,
    parameter int unsigned DATA_DFX_WIDTH    = decap_packet_pkg::DATA_DFX_WIDTH,
    parameter int unsigned NUMBER_PACKET     = decap_packet_pkg::NUMBER_PACKET,
    parameter int unsigned HEADER_WIDTH      = decap_packet_pkg::HEADER_WIDTH,
    parameter int unsigned AURORA_DATA_WIDTH = 64,
    parameter int unsigned PAYLOAD_WIDTH     = decap_packet_pkg::PAYLOAD_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES    = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [AURORA_DATA_WIDTH-1:0]       data_out_port_0,
    input  logic                               data_decap_valid,
    output logic [DATA_WIDTH+ADDR_WIDTH-1:0]   data_dfx_recv,
    output logic [HEADER_WIDTH-1:0]            header_pkt_recv,
    output logic                               dfx_recv_valid,
    input  logic                               dfx_recv_ready,
    output logic                               hdr_err,
    output logic                               timeout_err,
    output logic                               overflow_err
);

    // Last flit index and the number of payload bits it carries
    localparam int unsigned LAST_IDX  = NUMBER_PACKET - 1;
    localparam int unsigned TAIL_BITS = DATA_DFX_WIDTH - LAST_IDX * PAYLOAD_WIDTH;

    decap_state_e              state_q;
    decap_state_e              state_d;
    logic [INDEX_WIDTH-1:0]    idx_q;
    logic [INDEX_WIDTH-1:0]    idx_d;
    pkt_header_t               hdr_q;
    pkt_header_t               hdr_d;
    logic [DATA_DFX_WIDTH-1:0] asm_q;
    logic [DATA_DFX_WIDTH-1:0] asm_d;
    logic [DATA_DFX_WIDTH-1:0] dout_q;
    logic [DATA_DFX_WIDTH-1:0] dout_d;
    pkt_header_t               hout_q;
    pkt_header_t               hout_d;
    logic                      vld_q;
    logic                      vld_d;
    logic                      hdr_err_q;
    logic                      hdr_err_d;
    logic                      to_err_q;
    logic                      to_err_d;
    logic                      ovf_err_q;
    logic                      ovf_err_d;

    pkt_header_t               flit_hdr;
    logic [PAYLOAD_WIDTH-1:0]  flit_pay;
    logic [TAIL_BITS-1:0]      flit_tail;
    logic                      collecting;
    logic                      hdr_mismatch;
    logic                      last_flit;
    logic                      complete;
    logic                      can_load;
    logic                      gap_clear;
    logic                      gap_enable;
    logic                      gap_expired;

    // Flit field split
    assign flit_hdr  = pkt_header_t'(data_out_port_0[HEADER_WIDTH-1:0]);
    assign flit_pay  = data_out_port_0[HEADER_WIDTH +: PAYLOAD_WIDTH];
    assign flit_tail = data_out_port_0[HEADER_WIDTH +: TAIL_BITS];

    assign collecting   = (state_q == ST_COLLECT);
    assign hdr_mismatch = (flit_hdr != hdr_q);
    assign last_flit    = (idx_q == INDEX_WIDTH'(LAST_IDX));
    assign complete     = collecting && data_decap_valid && !hdr_mismatch && last_flit;
    // Output register can take a new word if empty or being drained this cycle
    assign can_load     = !vld_q || dfx_recv_ready;

    // Idle gaps are only timed while a packet is open
    assign gap_clear  = !collecting || data_decap_valid;
    assign gap_enable = collecting && !data_decap_valid;

    flit_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (gap_clear),
        .enable  (gap_enable),
        .expired (gap_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (data_decap_valid) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (gap_expired) begin
                    state_d = ST_IDLE;
                end else if (data_decap_valid && (hdr_mismatch || last_flit)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        idx_d     = idx_q;
        hdr_d     = hdr_q;
        asm_d     = asm_q;
        dout_d    = dout_q;
        hout_d    = hout_q;
        vld_d     = vld_q;
        hdr_err_d = 1'b0;
        to_err_d  = 1'b0;
        ovf_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_decap_valid) begin
                    hdr_d                    = flit_hdr;
                    asm_d[PAYLOAD_WIDTH-1:0] = flit_pay;
                    idx_d                    = INDEX_WIDTH'(1);
                end
            end
            ST_COLLECT: begin
                if (gap_expired) begin
                    to_err_d = 1'b1;
                    idx_d    = '0;
                end else if (data_decap_valid) begin
                    if (hdr_mismatch) begin
                        // Offending flit is dropped; it does not open a packet
                        hdr_err_d = 1'b1;
                        idx_d     = '0;
                    end else if (last_flit) begin
                        asm_d[LAST_IDX*PAYLOAD_WIDTH +: TAIL_BITS] = flit_tail;
                        idx_d = '0;
                    end else begin
                        // Constant-slice decode of the flit slot
                        for (int unsigned k = 1; k < LAST_IDX; k++) begin
                            if (idx_q == INDEX_WIDTH'(k)) begin
                                asm_d[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = flit_pay;
                            end
                        end
                        idx_d = idx_q + INDEX_WIDTH'(1);
                    end
                end
            end
            default: begin
                idx_d = '0;
            end
        endcase

        // Drain, then possibly reload in the same cycle
        if (vld_q && dfx_recv_ready) begin
            vld_d = 1'b0;
        end
        if (complete) begin
            if (can_load) begin
                dout_d = asm_d;
                hout_d = hdr_q;
                vld_d  = 1'b1;
            end else begin
                ovf_err_d = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            hdr_q     <= '0;
            asm_q     <= '0;
            dout_q    <= '0;
            hout_q    <= '0;
            vld_q     <= 1'b0;
            hdr_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            ovf_err_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            hdr_q     <= hdr_d;
            asm_q     <= asm_d;
            dout_q    <= dout_d;
            hout_q    <= hout_d;
            vld_q     <= vld_d;
            hdr_err_q <= hdr_err_d;
            to_err_q  <= to_err_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    assign data_dfx_recv   = dout_q;
    assign header_pkt_recv = hout_q;
    assign dfx_recv_valid  = vld_q;
    assign hdr_err         = hdr_err_q;
    assign timeout_err     = to_err_q;
    assign overflow_err    = ovf_err_q;

endmodule

// File: tb/tb_decap_packet.sv
// Self-checking bench for decap_packet. A flit-queue model predicts every
// output each cycle; directed scenarios add literal expectations.
module tb_decap_packet;

    localparam int unsigned W = 1034;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          valid = 1'b0;
    logic          ready = 1'b1;
    logic [63:0]   flit  = '0;

    logic [W-1:0]  data_dfx_recv;
    logic [8:0]    header_pkt_recv;
    logic          dfx_recv_valid;
    logic          hdr_err;
    logic          timeout_err;
    logic          overflow_err;

    decap_packet dut (
        .clk              (clk),
        .rst              (rst),
        .data_out_port_0  (flit),
        .data_decap_valid (valid),
        .data_dfx_recv    (data_dfx_recv),
        .header_pkt_recv  (header_pkt_recv),
        .dfx_recv_valid   (dfx_recv_valid),
        .dfx_recv_ready   (ready),
        .hdr_err          (hdr_err),
        .timeout_err      (timeout_err),
        .overflow_err     (overflow_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            int first;
            first = 0;
            for (int b = W - 1; b >= 0; b--) if (act[b] !== exp[b]) first = b;
            n_fail++;
            $display("FAIL %s: first differing bit %0d got %b required %b", name, first, act[first], exp[first]);
        end
    endtask

    // ---------------- model: queue of accepted flits ----------------
    logic [63:0]  q[$];
    int           idle_cnt = 0;
    logic         m_valid  = 1'b0;
    logic [W-1:0] m_data   = '0;
    logic [8:0]   m_hdr    = '0;
    logic         m_herr   = 1'b0;
    logic         m_terr   = 1'b0;
    logic         m_oerr   = 1'b0;

    // Word bit b comes from flit b/55, payload bit b%55 (flit bit 9 + b%55)
    function automatic logic [W-1:0] assemble();
        logic [W-1:0] w;
        w = '0;
        for (int b = 0; b < W; b++) w[b] = q[b / 55][9 + (b % 55)];
        return w;
    endfunction

    // Advance the model by the clock edge that will sample the current inputs
    task automatic step_model();
        logic can_load;
        m_herr = 1'b0;
        m_terr = 1'b0;
        m_oerr = 1'b0;
        if (rst) begin
            q.delete();
            idle_cnt = 0;
            m_valid  = 1'b0;
            m_data   = '0;
            m_hdr    = '0;
        end else begin
            can_load = !m_valid || ready;
            if (m_valid && ready) m_valid = 1'b0;
            if (valid) begin
                idle_cnt = 0;
                if (q.size() != 0 && flit[8:0] != q[0][8:0]) begin
                    m_herr = 1'b1;
                    q.delete();
                end else begin
                    q.push_back(flit);
                    if (q.size() == 19) begin
                        if (can_load) begin
                            m_valid = 1'b1;
                            m_data  = assemble();
                            m_hdr   = q[0][8:0];
                        end else begin
                            m_oerr = 1'b1;
                        end
                        q.delete();
                    end
                end
            end else if (q.size() != 0) begin
                idle_cnt++;
                if (idle_cnt == 32) begin
                    m_terr = 1'b1;
                    q.delete();
                    idle_cnt = 0;
                end
            end
        end
    endtask

    // ---------------- compare process + event counters ----------------
    int n_hs = 0, n_herr = 0, n_terr = 0, n_oerr = 0, cyc = 0;
    int hs_cyc[$];

    always @(negedge clk) begin
        cyc++;
        check("valid", 64'(dfx_recv_valid), 64'(m_valid));
        check("hdr_err", 64'(hdr_err), 64'(m_herr));
        check("timeout_err", 64'(timeout_err), 64'(m_terr));
        check("overflow_err", 64'(overflow_err), 64'(m_oerr));
        check("header", 64'(header_pkt_recv), 64'(m_hdr));
        check_word("data", data_dfx_recv, m_data);
        if (dfx_recv_valid && ready) begin
            n_hs++;
            hs_cyc.push_back(cyc);
        end
        if (hdr_err) n_herr++;
        if (timeout_err) n_terr++;
        if (overflow_err) n_oerr++;
        step_model();
    end

    task automatic clear_counts();
        n_hs = 0; n_herr = 0; n_terr = 0; n_oerr = 0;
        hs_cyc.delete();
    endtask

    // ---------------- stimulus ----------------
    function automatic logic [54:0] pay(input int mode, input int k);
        case (mode)
            0:       pay = 55'h1 << k;
            1:       pay = 55'h1;
            2:       pay = 55'(k + 1);
            3:       pay = 55'(k + 100);
            default: pay = 55'h2A_5A5A_5A5A_5A5A ^ 55'(k * 7);
        endcase
    endfunction

    task automatic send_flit(input logic [63:0] f);
        @(posedge clk); #1;
        valid = 1'b1;
        flit  = f;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        valid = 1'b0;
        flit  = '0;
    endtask

    task automatic send_pkt(input logic [8:0] hdr, input int mode);
        for (int k = 0; k < 19; k++) send_flit({pay(mode, k), hdr});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [54:0] slice;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(dfx_recv_valid), 64'd0);
        check("rst_hdr", 64'(header_pkt_recv), 64'd0);
        check("rst_errs", 64'({hdr_err, timeout_err, overflow_err}), 64'd0);
        check_word("rst_data", data_dfx_recv, '0);
        rst = 1'b0;
        idle_cycle();

        // Single packet, payload k = 1 << k
        for (int k = 0; k < 19; k++) begin
            send_flit({pay(0, k), 9'h0A5});
            if (k == 18) check("t1_early_valid", 64'(dfx_recv_valid), 64'd0);
        end
        idle_cycle();
        check("t1_valid", 64'(dfx_recv_valid), 64'd1);
        check("t1_hdr", 64'(header_pkt_recv), 64'h0A5);
        for (int k = 0; k < 18; k++) check("t1_bit", 64'(data_dfx_recv[k * 56]), 64'd1);
        check("t1_bit1008", 64'(data_dfx_recv[1008]), 64'd1);
        check("t1_ones", 64'($countones(data_dfx_recv)), 64'd19);
        idle_cycle();
        check("t1_drained", 64'(dfx_recv_valid), 64'd0);

        // Single packet, payload LSB only
        send_pkt(9'h0A5, 1);
        idle_cycle();
        for (int k = 0; k < 18; k++) check("t1b_bit", 64'(data_dfx_recv[k * 55]), 64'd1);
        check("t1b_bit990", 64'(data_dfx_recv[990]), 64'd1);
        check("t1b_ones", 64'($countones(data_dfx_recv)), 64'd19);
        idle_cycle();

        // Header mismatch at flit 7
        clear_counts();
        for (int k = 0; k < 8; k++) send_flit({pay(2, k), (k == 7) ? 9'h0A6 : 9'h0A5});
        idle_cycle();
        check("t2_hdr_err", 64'(hdr_err), 64'd1);
        repeat (2) idle_cycle();
        check("t2_herr_cnt", 64'(n_herr), 64'd1);
        check("t2_no_valid", 64'(n_hs), 64'd0);
        send_pkt(9'h0A5, 4);
        idle_cycle();
        idle_cycle();
        check("t2_clean", 64'(n_hs), 64'd1);

        // Timeout after 10 flits
        clear_counts();
        for (int k = 0; k < 10; k++) send_flit({pay(2, k), 9'h133});
        idle_cycle();
        for (int i = 1; i <= 33; i++) begin
            idle_cycle();
            check("t3_timeout", 64'(timeout_err), 64'(i == 32));
        end
        check("t3_terr_cnt", 64'(n_terr), 64'd1);
        send_pkt(9'h133, 2);
        idle_cycle();
        idle_cycle();
        check("t3_clean", 64'(n_hs), 64'd1);

        // Backpressure: second packet overflows, first is held
        clear_counts();
        ready = 1'b0;
        send_pkt(9'h0A5, 2);
        send_pkt(9'h0A5, 3);
        idle_cycle();
        check("t4_overflow", 64'(overflow_err), 64'd1);
        check("t4_held", 64'(dfx_recv_valid), 64'd1);
        slice = data_dfx_recv[54:0];
        check("t4_first_data", 64'(slice), 64'd1);
        @(posedge clk); #1;
        ready = 1'b1;
        idle_cycle();
        check("t4_read_once", 64'(n_hs), 64'd1);
        check("t4_cleared", 64'(dfx_recv_valid), 64'd0);
        check("t4_oerr_cnt", 64'(n_oerr), 64'd1);

        // Three back-to-back packets, ready high
        clear_counts();
        send_pkt(9'h0A5, 0);
        send_pkt(9'h1C3, 4);
        send_pkt(9'h055, 2);
        repeat (2) idle_cycle();
        check("t5_pulses", 64'(n_hs), 64'd3);
        if (hs_cyc.size() == 3) begin
            check("t5_gap01", 64'(hs_cyc[1] - hs_cyc[0]), 64'd19);
            check("t5_gap12", 64'(hs_cyc[2] - hs_cyc[1]), 64'd19);
        end
        check("t5_no_errs", 64'(n_herr + n_terr + n_oerr), 64'd0);

        // Reset mid-packet with a held output and a flit during reset
        clear_counts();
        ready = 1'b0;
        send_pkt(9'h0A5, 2);
        for (int k = 0; k < 6; k++) send_flit({pay(4, k), 9'h0A5});
        @(posedge clk); #1;
        rst  = 1'b1;
        flit = {pay(4, 6), 9'h0A5};
        @(posedge clk); #1;
        rst   = 1'b0;
        valid = 1'b0;
        check("t6_valid", 64'(dfx_recv_valid), 64'd0);
        check("t6_hdr", 64'(header_pkt_recv), 64'd0);
        check_word("t6_data", data_dfx_recv, '0);
        ready = 1'b1;
        send_pkt(9'h1FF, 4);
        idle_cycle();
        check("t6_hdr_after", 64'(header_pkt_recv), 64'h1FF);
        idle_cycle();
        check("t6_one_word", 64'(n_hs), 64'd1);
        check("t6_no_errs", 64'(n_herr + n_terr + n_oerr), 64'd0);

        repeat (2) idle_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
